// File: rtl/encoder_4to2_if.sv
// Request/encoded-index bundle for the registered 4-to-2 encoder.
// The master drives the request lines and the slave (encoder) returns out/valid/err.
interface encoder_4to2_if;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [1:0] out;
    logic       valid;
    logic       err;

    modport master (output a, b, c, d, input out, valid, err);
    modport slave  (input a, b, c, d, output out, valid, err);
endinterface

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 encoder: one-cycle index of the active request line,
// plus idle (valid=0) and multi-hot (err=1) flags.
module encoder_4to2 #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    encoder_4to2_if.slave  bus
);

    logic [3:0] w_req;
    logic [1:0] w_code;
    logic       w_any;
    logic       w_multi;

    logic [1:0] r_out;
    logic       r_valid;
    logic       r_err;

    assign w_req   = {bus.a, bus.b, bus.c, bus.d};
    assign w_any   = |w_req;
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign w_multi = |(w_req & (w_req - 4'd1));

    // Later loop iterations override earlier ones, so scan order sets the winner.
    always_comb begin
        w_code = 2'b00;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 4; i++) begin
                if (w_req[i]) w_code = 2'(i);
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (w_req[i]) w_code = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= 2'b00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_out   <= w_code;
            r_valid <= w_any;
            r_err   <= w_multi;
        end
    end

    assign bus.out   = r_out;
    assign bus.valid = r_valid;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_encoder_4to2.sv
// Bench for encoder_4to2: both priority settings driven with identical requests
// and checked against a counting/scanning reference model.
module tb_encoder_4to2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    encoder_4to2_if if_hi ();
    encoder_4to2_if if_lo ();

    encoder_4to2 #(.PRIORITY_HIGH(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(if_hi));
    encoder_4to2 #(.PRIORITY_HIGH(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(if_lo));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {out[1:0], valid, err} from the block's rules.
    function automatic logic [3:0] model(input logic [3:0] req, input bit hi, input bit r);
        int n;
        int idx;
        n   = $countones(req);
        idx = 0;
        if (r || n == 0) return 4'b0000;
        if (hi) begin
            for (int i = 3; i >= 0; i--) if (req[i]) begin idx = i; break; end
        end else begin
            for (int i = 0; i < 4; i++) if (req[i]) begin idx = i; break; end
        end
        return {idx[1:0], 1'b1, (n > 1)};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed out/valid/err=%b/%b/%b expected %b/%b/%b",
                   tag, obs[3:2], obs[1], obs[0], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of requests, let the edge happen, then check both DUTs.
    task automatic step(input string tag, input logic [3:0] req, input bit r);
        rst = r;
        {if_hi.a, if_hi.b, if_hi.c, if_hi.d} = req;
        {if_lo.a, if_lo.b, if_lo.c, if_lo.d} = req;
        @(posedge clk);
        #1;
        check({tag, "_hi"}, {if_hi.out, if_hi.valid, if_hi.err}, model(req, 1'b1, r));
        check({tag, "_lo"}, {if_lo.out, if_lo.valid, if_lo.err}, model(req, 1'b0, r));
    endtask

    initial begin
        logic [3:0] req;
        bit         r;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        @(negedge clk);

        step("rst_all_hi_0", 4'b1111, 1'b1);
        step("rst_all_hi_1", 4'b1111, 1'b1);
        step("onehot_d", 4'b0001, 1'b0);
        step("onehot_c", 4'b0010, 1'b0);
        step("onehot_b", 4'b0100, 1'b0);
        step("onehot_a", 4'b1000, 1'b0);
        step("idle", 4'b0000, 1'b0);
        step("multi_0101", 4'b0101, 1'b0);
        step("multi_1111", 4'b1111, 1'b0);
        step("multi_1010", 4'b1010, 1'b0);
        step("hold_a", 4'b1000, 1'b0);
        step("rst_pulse_a", 4'b1000, 1'b1);
        step("resume_a", 4'b1000, 1'b0);

        for (int k = 0; k < 300; k++) begin
            req = 4'($urandom_range(0, 15));
            r   = ($urandom_range(0, 15) == 0);
            step("random", req, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
